// File: rtl/rr_chan_array_writer_pkg.sv
// Shared helpers and types for the round-robin channel array writer.
// Optional parity storage is enabled by RR_CHAN_ARRAY_PARITY_EN.
package rr_chan_array_pkg;

    // Default geometry used by the bundled request type.
    localparam int WIDTH = 8;
    localparam int IDX_W = 2;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
        logic [WIDTH-1:0] data;
    } req_t;

    // $clog2 that never returns 0, so single-entry configs keep a 1-bit field.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/rr_chan_array_writer_if.sv
// Request/read/status bundle between requesters and the array writer.
// Parity test/status signals exist only with RR_CHAN_ARRAY_PARITY_EN.
interface rr_chan_array_writer_if
    import rr_chan_array_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = 2,
    parameter int WIDTH  = 8
);
    localparam int CH_W = clog2_min1(NUM_CH);

    logic [NUM_CH-1:0]             req_valid;
    logic [NUM_CH-1:0]             req_ready;
    logic [NUM_CH-1:0][IDX_W-1:0]  req_idx;
    logic [NUM_CH-1:0][WIDTH-1:0]  req_data;
    logic [IDX_W-1:0]              rd_idx;
    logic [WIDTH-1:0]              rd_data;
    logic                          grant_valid;
    logic [CH_W-1:0]               grant_ch;
    logic                          err_oob;
`ifdef RR_CHAN_ARRAY_PARITY_EN
    logic                          inj_perr;
    logic                          rd_perr;
`endif

    modport master (
`ifdef RR_CHAN_ARRAY_PARITY_EN
        output inj_perr,
        input  rd_perr,
`endif
        output req_valid, req_idx, req_data, rd_idx,
        input  req_ready, rd_data, grant_valid, grant_ch, err_oob
    );

    modport slave (
`ifdef RR_CHAN_ARRAY_PARITY_EN
        input  inj_perr,
        output rd_perr,
`endif
        input  req_valid, req_idx, req_data, rd_idx,
        output req_ready, rd_data, grant_valid, grant_ch, err_oob
    );

endinterface

// File: rtl/rr_chan_array_writer_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and ascends
// modulo NUM_CH; the first asserted request wins.
module rr_arbiter
    import rr_chan_array_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = clog2_min1(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    input  logic              en,
    output logic [NUM_CH-1:0] gnt,
    output logic [CH_W-1:0]   gnt_idx
);
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (en && !found && req[(int'(ptr) + k) % NUM_CH]) begin
                found                          = 1'b1;
                gnt[(int'(ptr) + k) % NUM_CH] = 1'b1;
                gnt_idx                        = CH_W'((int'(ptr) + k) % NUM_CH);
            end
        end
    end

endmodule

// File: rtl/rr_chan_array_writer.sv
// NUM_CH requesters write round-robin into one DEPTH x WIDTH register array.
// Define RR_CHAN_ARRAY_PARITY_EN to store/check an even-parity bit per entry.
module rr_chan_array_writer
    import rr_chan_array_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 4,
    parameter int WIDTH  = 8,
    parameter int IDX_W  = clog2_min1(DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    rr_chan_array_writer_if.slave bus
);
    localparam int CH_W = clog2_min1(NUM_CH);
`ifdef RR_CHAN_ARRAY_PARITY_EN
    localparam int EW = WIDTH + 1;
`else
    localparam int EW = WIDTH;
`endif

    logic [DEPTH-1:0][EW-1:0] mem;
    logic [CH_W-1:0]          ptr;
    logic [CH_W-1:0]          gidx;
    logic [NUM_CH-1:0]        gnt;
    logic                     xfer;
    logic                     wr_oob;
    logic                     rd_oob;
    logic [IDX_W-1:0]         wr_idx;
    logic [WIDTH-1:0]         wr_data;
    logic [EW-1:0]            wr_word;
    logic [EW-1:0]            rd_word;
    logic                     grant_valid_q;
    logic [CH_W-1:0]          grant_ch_q;
    logic                     err_oob_q;

    // Arbitration is gated off by reset so nothing handshakes during it.
    rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
        .req     (bus.req_valid),
        .ptr     (ptr),
        .en      (~reset),
        .gnt     (gnt),
        .gnt_idx (gidx)
    );

    assign bus.req_ready = gnt;
    assign xfer          = |gnt;
    assign wr_idx        = bus.req_idx[gidx];
    assign wr_data       = bus.req_data[gidx];

    // Out-of-range indices only exist when DEPTH leaves index codes unused.
    generate
        if (DEPTH == (1 << IDX_W)) begin : g_pow2
            assign wr_oob = 1'b0;
            assign rd_oob = 1'b0;
        end else begin : g_npow2
            assign wr_oob = wr_idx      > IDX_W'(DEPTH - 1);
            assign rd_oob = bus.rd_idx  > IDX_W'(DEPTH - 1);
        end
    endgenerate

`ifdef RR_CHAN_ARRAY_PARITY_EN
    assign wr_word     = {even_parity(64'(wr_data)) ^ bus.inj_perr, wr_data};
    // A clean word (data plus parity) always reduces to zero.
    assign bus.rd_perr = ^rd_word;
`else
    assign wr_word     = wr_data;
`endif

    assign rd_word         = rd_oob ? '0 : mem[bus.rd_idx];
    assign bus.rd_data     = rd_word[WIDTH-1:0];
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_ch    = grant_ch_q;
    assign bus.err_oob     = err_oob_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            mem           <= '0;
            ptr           <= '0;
            grant_valid_q <= 1'b0;
            grant_ch_q    <= '0;
            err_oob_q     <= 1'b0;
        end else begin
            grant_valid_q <= xfer;
            if (xfer) begin
                grant_ch_q <= gidx;
                ptr        <= (gidx == CH_W'(NUM_CH - 1)) ? '0 : gidx + 1'b1;
                if (wr_oob)
                    err_oob_q <= 1'b1;
                else
                    mem[wr_idx] <= wr_word;
            end
        end
    end

endmodule
